fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries, a power of two and at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-007 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-008 SHALL have port imem_req_addr, output, XLEN bits: fetch address, word aligned.
REQ-009 SHALL have port imem_rsp_valid, input, 1 bit: instruction returned, in request order, with variable latency of at least 1 cycle.
REQ-010 SHALL have port imem_rsp_data, input, XLEN bits: returned instruction.
REQ-011 SHALL have port if_valid, output, 1 bit: the queue head is valid toward decode.
REQ-012 SHALL have port if_ready, input, 1 bit: decode consumes the head (~stall_D).
REQ-013 SHALL have port if_instr, output, XLEN bits: head instruction.
REQ-014 SHALL have port if_pc, output, XLEN bits: head PC.
REQ-015 SHALL have port if_npc, output, XLEN bits: head PC + 4.
REQ-016 SHALL have port redirect_valid, input, 1 bit: branch, call or jmpl redirect (nPC_sel != 0).
REQ-017 SHALL have port redirect_pc, input, XLEN bits: redirect target (TAG or ALU output).
REQ-018 SHALL have port halt, input, 1 bit: suppress new requests.
REQ-019 SHALL have port err, output, 1 bit: sticky flag for a protocol violation.

Function
REQ-020 SHALL implement the states IDLE, FETCH and HALTED: IDLE lasts the first cycle after reset release and goes to FETCH; FETCH goes to HALTED while halt=1; HALTED goes to FETCH when halt=0.
REQ-021 SHALL drive imem_req_valid=1 only in FETCH, with redirect_valid=0, and inflight+count < DEPTH (credit rule).
REQ-022 SHALL treat a request as accepted on imem_req_valid&imem_req_ready; on acceptance fetch_pc += 4 (modulo 2^XLEN, wraps silently) and inflight++.
REQ-023 SHALL push a response with imem_rsp_valid=1 and discard=0 as {data, pc-tag}; the pc-tag is taken from a PC tag FIFO of DEPTH entries filled at acceptance; inflight-- on the push.
REQ-024 SHALL give a response a latency of exactly 1 cycle from push to if_valid, with no bypass from rsp to if_*.
REQ-025 SHALL pop the head on if_valid&if_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-026 SHALL, by the credit rule, never push into a full queue; a response arriving with inflight=0 SHALL be dropped and set err.
REQ-027 SHALL, on redirect_valid, in that cycle: clear the queue (count=0, if_valid=0 next cycle), set fetch_pc<=redirect_pc, set discard<=inflight minus (1 if a response arrives that same cycle), and drop that same-cycle response.
REQ-028 SHALL drop responses while discard>0, decrementing discard and inflight; requests MAY issue to the new PC during the drain.
REQ-029 SHALL give redirect priority over pop, push and halt in the same cycle; a consumed head in that cycle is still counted as delivered.
REQ-030 SHALL keep imem_req_addr and imem_req_valid stable while valid=1 and ready=0, unless a redirect occurs.
REQ-031 SHALL leave delay-slot ordering to the producer of redirect_valid; the block flushes all queued entries.

Reset
REQ-032 SHALL, while reset=0, asynchronously force: state=IDLE, fetch_pc=RESET_PC, count=0, inflight=0, discard=0, imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0, if_npc=0, err=0.
REQ-033 SHALL drop, after reset release, any response to a pre-reset request (inflight=0), which sets err; the bench SHALL quiesce memory around reset.

Structure
REQ-034 SHALL place the state enum, the default XLEN, RESET_PC and the constant 4 (instruction size) in shared package ppu_pkg.
REQ-035 SHALL use one sub-module, fetch_fifo, a parametrised circular buffer (width and DEPTH, wrap pointers plus a count), instantiated for the data+PC queue and for the PC tag FIFO.

Verification
REQ-036 Scenario: reset release, imem latency 1, if_ready=1 -> first if_pc=RESET_PC, then +4 each cycle, with if_npc=if_pc+4.
REQ-037 Scenario: DEPTH=4, if_ready=0 for 10 cycles -> exactly 4 requests accepted, if_valid=1, imem_req_valid=0 afterwards.
REQ-038 Scenario: latency 3, redirect_pc=0x40 with 2 inflight -> those 2 responses dropped, next if_pc=0x40, no stale PC delivered.
REQ-039 Scenario: redirect in the same cycle as rsp_valid and if_ready -> the response dropped, discard equals prior inflight-1, the head consumed once.
REQ-040 Scenario: imem_req_ready=0 for 5 cycles with a request pending -> the address is held constant and fetch_pc advances only on acceptance.
REQ-041 Scenario: reset asserted mid-burst, then rsp_valid pulsed -> all outputs at reset values and err=1.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared definitions for the instruction fetch path.
//   XLEN_DEFAULT     : default address / instruction width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INSTR_BYTES      : instruction size in bytes (fetch PC increment)
//   fetch_state_e    : fetch controller states
package ppu_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Parametrised circular buffer with wrapping pointers and an occupancy count.
// Ports:
//   clk, reset     : clock, async active-low reset
//   flush          : synchronous clear (pointers and count to zero)
//   push/push_data : write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head           : current head entry (meaningless while count == 0)
//   count          : number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: readers qualify head with count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word-aligned fetch requests under a credit
// limit, pairs in-order responses with their PCs and presents them to decode.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | first cycle after reset release, no requests
//   ST_FETCH  | requests issue while credit allows
//   ST_HALTED | halt asserted, no new requests
//
// Ports:
//   clk, reset                      : clock, async active-low reset
//   imem_req_valid/ready/addr       : fetch request channel
//   imem_rsp_valid/data             : in-order response channel
//   if_valid/ready/instr/pc/npc     : head of queue toward decode
//   redirect_valid/pc               : flush and restart fetch at redirect_pc
//   halt                            : suppress new requests
//   err                             : sticky, response with nothing outstanding
module fetch_queue
  import ppu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_npc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            err
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   tag_count;
  logic [XLEN-1:0] tag_head;
  logic [XLEN-1:0] q_instr;
  logic [XLEN-1:0] q_pc;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_live;
  logic            rsp_orphan;
  logic            rsp_push;
  logic            tag_missing;
  logic            if_pop;

  // Outstanding requests plus queued entries never exceed DEPTH, so a
  // returning response always has a free queue slot.
  assign credit_used    = {1'b0, inflight} + {1'b0, q_count};
  assign imem_req_valid = (state == ST_FETCH) && !redirect_valid &&
                          (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_orphan  = imem_rsp_valid && (inflight == '0);
  assign rsp_live    = imem_rsp_valid && (inflight != '0);
  assign rsp_push    = rsp_live && !redirect_valid && (discard == '0) && (tag_count != '0);
  assign tag_missing = rsp_live && !redirect_valid && (discard == '0) && (tag_count == '0);

  assign if_valid = (q_count != '0);
  assign if_pop   = if_valid && if_ready && !redirect_valid;
  assign if_instr = if_valid ? q_instr : '0;
  assign if_pc    = if_valid ? q_pc : '0;
  assign if_npc   = if_valid ? (q_pc + XLEN'(INSTR_BYTES)) : '0;

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_data_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_data ({imem_rsp_data, tag_head}),
    .pop       (if_pop),
    .head      ({q_instr, q_pc}),
    .count     (q_count)
  );

  // Tags of requests whose responses will be kept. Cleared on redirect:
  // responses still owed to the old path are accounted for by discard.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_push),
    .head      (tag_head),
    .count     (tag_count)
  );

  // FETCH holds off entering HALTED while a request is stalled on ready so
  // that an offered request is never withdrawn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state <= ST_FETCH;
        ST_FETCH:  if (halt && !(imem_req_valid && !imem_req_ready)) state <= ST_HALTED;
        ST_HALTED: if (!halt) state <= ST_FETCH;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      err      <= 1'b0;
    end else begin
      err <= err | rsp_orphan | tag_missing;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        inflight <= inflight - CW'(rsp_live);
        discard  <= inflight - CW'(rsp_live);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        inflight <= inflight + CW'(req_fire) - CW'(rsp_live);
        if (rsp_live && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        err;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_npc         (if_npc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          dlv_cnt = 0;
  logic [31:0] model_pc = RPC;
  logic [31:0] last_pc = '0;
  bit          gnt = 0, rdy_if = 0, redir = 0, rsp_en = 1, halt_i = 0;
  logic [31:0] redir_pc = '0;
  int          lat = 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a00_00a5;
  endfunction

  // One clock cycle: drive inputs, sample at negedge, update models.
  task automatic cycle();
    bit    rsp_fire;
    mreq_t m;
    logic [31:0] e;
    imem_req_ready = gnt;
    if_ready       = rdy_if;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    halt           = halt_i;
    rsp_fire       = rsp_en && (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp_fire;
    imem_rsp_data  = rsp_fire ? instr_of(memq[0].addr) : '0;
    @(negedge clk);
    if (redirect_valid) begin
      n_checks++;
      if (imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL req_during_redirect: req_valid=%b required 0", imem_req_valid);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      n_checks++;
      if (imem_req_addr !== model_pc) begin
        n_fail++;
        $display("FAIL req_addr: got %h required %h", imem_req_addr, model_pc);
      end
      m.addr = imem_req_addr;
      m.due  = cyc + lat;
      memq.push_back(m);
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
      acc_cnt++;
    end
    if (if_valid && if_ready) begin
      dlv_cnt++;
      last_pc = if_pc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_delivery: pc=%h with nothing expected", if_pc);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e || if_instr !== instr_of(e) || if_npc !== e + 32'd4) begin
          n_fail++;
          $display("FAIL delivery: pc=%h instr=%h npc=%h required pc=%h instr=%h npc=%h",
                   if_pc, if_instr, if_npc, e, instr_of(e), e + 32'd4);
        end
      end
    end
    if (redir) begin
      exp_q.delete();
      model_pc = redir_pc;
    end
    if (rsp_fire) void'(memq.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    gnt = 0; rdy_if = 1; rsp_en = 1; redir = 0; halt_i = 0;
    for (int i = 0; i < 60 && !(memq.size() == 0 && !if_valid); i++) cycle();
    n_checks++;
    if (memq.size() != 0 || if_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: memq=%0d if_valid=%b undelivered=%0d required 0/0/0",
               memq.size(), if_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req_valid=%b if_valid=%b err=%b required 0",
               imem_req_valid, if_valid, err);
    end
    n_checks++;
    if (if_instr !== '0 || if_pc !== '0 || if_npc !== '0) begin
      n_fail++;
      $display("FAIL reset_data: instr=%h pc=%h npc=%h required 0", if_instr, if_pc, if_npc);
    end
    n_checks++;
    if (imem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL reset_addr: got %h required %h", imem_req_addr, RPC);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle();
    n_checks++;
    if (imem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_to_fetch: req_valid=%b required 1", imem_req_valid);
    end
  endtask

  task automatic test_stream();
    int d0;
    lat = 1; gnt = 1; rdy_if = 1;
    d0 = dlv_cnt;
    for (int i = 0; i < 10 && dlv_cnt == d0; i++) cycle();
    n_checks++;
    if (dlv_cnt == d0 || last_pc !== RPC) begin
      n_fail++;
      $display("FAIL first_pc: got %h (deliveries %0d) required %h", last_pc, dlv_cnt - d0, RPC);
    end
    d0 = dlv_cnt;
    for (int i = 0; i < 12; i++) cycle();
    n_checks++;
    if (dlv_cnt - d0 != 12) begin
      n_fail++;
      $display("FAIL stream_rate: got %0d deliveries required 12", dlv_cnt - d0);
    end
    drain();
  endtask

  task automatic test_credit();
    int a0;
    lat = 1; gnt = 1; rdy_if = 0;
    a0 = acc_cnt;
    for (int i = 0; i < 10; i++) cycle();
    n_checks++;
    if (acc_cnt - a0 != 4) begin
      n_fail++;
      $display("FAIL credit_accepts: got %0d required 4", acc_cnt - a0);
    end
    n_checks++;
    if (if_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_full: if_valid=%b req_valid=%b required 1/0", if_valid, imem_req_valid);
    end
    drain();
  endtask

  task automatic test_redirect();
    int a0, d0;
    lat = 3; gnt = 1; rdy_if = 1;
    a0 = acc_cnt;
    for (int i = 0; i < 10 && acc_cnt - a0 < 2; i++) cycle();
    gnt = 0; redir = 1; redir_pc = 32'h40;
    cycle();
    redir = 0; gnt = 1;
    d0 = dlv_cnt;
    for (int i = 0; i < 30 && dlv_cnt == d0; i++) cycle();
    n_checks++;
    if (dlv_cnt == d0 || last_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL redirect_target: got %h required 00000040", last_pc);
    end
    for (int i = 0; i < 5; i++) cycle();
    drain();
  endtask

  task automatic test_wrap();
    lat = 1; gnt = 1; rdy_if = 1;
    redir = 1; redir_pc = 32'hffff_fff8;
    cycle();
    redir = 0;
    for (int i = 0; i < 8; i++) cycle();
    drain();
  endtask

  task automatic test_same_cycle();
    int  d0;
    bit  hit = 0;
    lat = 2; gnt = 1; rdy_if = 1;
    for (int i = 0; i < 6; i++) cycle();
    for (int i = 0; i < 20 && !hit; i++) begin
      if (memq.size() > 0 && memq[0].due <= cyc && if_valid) begin
        hit = 1;
        redir = 1; redir_pc = 32'h80;
        d0 = dlv_cnt;
        cycle();
        redir = 0;
        n_checks++;
        if (dlv_cnt - d0 != 1) begin
          n_fail++;
          $display("FAIL same_cycle_consume: got %0d deliveries required 1", dlv_cnt - d0);
        end
      end else begin
        cycle();
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL same_cycle_setup: got no rsp+head cycle required one");
    end
    d0 = dlv_cnt;
    for (int i = 0; i < 30 && dlv_cnt == d0; i++) cycle();
    n_checks++;
    if (dlv_cnt == d0 || last_pc !== 32'h80) begin
      n_fail++;
      $display("FAIL same_cycle_target: got %h required 00000080", last_pc);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_err: got %b required 0", err);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [31:0] held;
    bit          bad = 0;
    gnt = 0; rdy_if = 1; lat = 1;
    held = imem_req_addr;
    n_checks++;
    if (imem_req_valid !== 1'b1 || held !== model_pc) begin
      n_fail++;
      $display("FAIL stall_start: valid=%b addr=%h required 1/%h", imem_req_valid, held, model_pc);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (imem_req_valid !== 1'b1 || imem_req_addr !== held) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_hold: valid=%b addr=%h required 1/%h", imem_req_valid, imem_req_addr, held);
    end
    gnt = 1;
    cycle();
    gnt = 0;
    n_checks++;
    if (imem_req_addr !== held + 32'd4) begin
      n_fail++;
      $display("FAIL stall_advance: got %h required %h", imem_req_addr, held + 32'd4);
    end
    drain();
  endtask

  task automatic test_halt();
    int a0;
    lat = 1; gnt = 1; rdy_if = 1; halt_i = 1;
    cycle();
    cycle();
    a0 = acc_cnt;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_valid: got %b required 0", imem_req_valid);
    end
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (acc_cnt != a0) begin
      n_fail++;
      $display("FAIL halt_accepts: got %0d required 0", acc_cnt - a0);
    end
    halt_i = 0;
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (acc_cnt == a0) begin
      n_fail++;
      $display("FAIL halt_resume: got 0 accepts required >0");
    end
    drain();
  endtask

  task automatic test_reset_mid();
    mreq_t m;
    lat = 3; gnt = 1; rdy_if = 1;
    for (int i = 0; i < 4; i++) cycle();
    reset = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; if_ready = 0; redirect_valid = 0; halt = 0;
    gnt = 0; rdy_if = 0;
    #2;
    n_checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_instr !== '0 || if_pc !== '0 ||
        if_npc !== '0 || err !== 1'b0 || imem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: req_valid=%b if_valid=%b instr=%h pc=%h npc=%h err=%b addr=%h required zeros",
               imem_req_valid, if_valid, if_instr, if_pc, if_npc, err, imem_req_addr);
    end
    memq.delete();
    exp_q.delete();
    model_pc = RPC;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m.addr = 32'h100;
    m.due  = cyc;
    memq.push_back(m);
    rsp_en = 1;
    cycle();
    cycle();
    n_checks++;
    if (err !== 1'b1 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_rsp: err=%b if_valid=%b required 1/0", err, if_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_credit();
    test_redirect();
    test_wrap();
    test_same_cycle();
    test_stall();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
